// File: rtl/hum_fan_ctrl.sv
// -----------------------------------------------------------------------------
// hum_fan_ctrl
//
// Closed-loop humidity fan controller. It turns sparse humidity samples from
// the DHT11 readout path into a slew-limited duty command for the PWM
// generator. Band changes use hysteresis on the way down. The block also
// produces the period-alignment strobe that the PWM generator restarts on.
// A watchdog forces a safe duty if samples stop arriving.
//
// Ports
//   clk          system clock (single clock domain)
//   rst          asynchronous active-low reset
//   hum_valid    one-cycle strobe qualifying hum_int
//   hum_int[7:0] integer relative humidity, percent
//   duty[9:0]    high cycles per PWM period; changes only at a period boundary
//   period_sync  one-cycle pulse on the first cycle of each PWM period
//   fan_en       high while duty != 0
//   level[1:0]   current humidity band 0..3
//   fault        high while the sensor timeout is active
// -----------------------------------------------------------------------------
module hum_fan_ctrl #(
  parameter int unsigned PERIOD       = 1000,
  parameter int unsigned RAMP_PERIODS = 4,
  parameter int unsigned STEP         = 25,
  parameter int unsigned HYST         = 5,
  parameter int unsigned TIMEOUT      = 150_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hum_valid,
  input  logic [7:0] hum_int,
  output logic [9:0] duty,
  output logic       period_sync,
  output logic       fan_en,
  output logic [1:0] level,
  output logic       fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FAULT
  } state_t;

  localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

  localparam logic [9:0]    P_LAST   = 10'(PERIOD - 1);
  localparam logic [RW-1:0] R_LAST   = RW'(RAMP_PERIODS - 1);
  localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [9:0]    STEP_W   = 10'(STEP);

  // Target duties: (PERIOD-1)*pct/100, truncated. Band 3 switches the fan off.
  localparam logic [9:0] TGT_L0   = 10'((PERIOD - 1) * 20 / 100);
  localparam logic [9:0] TGT_L1   = 10'((PERIOD - 1) * 50 / 100);
  localparam logic [9:0] TGT_L2   = 10'((PERIOD - 1) * 80 / 100);
  localparam logic [9:0] TGT_SAFE = 10'((PERIOD - 1) * 50 / 100);

  state_t        state;
  logic [9:0]    pcnt;
  logic [RW-1:0] rcnt;
  logic [31:0]   tcnt;

  logic          accept;
  logic          expire;
  logic [8:0]    h_ext;
  logic [8:0]    h_hyst;
  logic [1:0]    band_h;
  logic [1:0]    band_hyst;
  logic [1:0]    run_level;
  logic [9:0]    target;
  logic [9:0]    duty_nxt;

  function automatic logic [1:0] band(input logic [8:0] h);
    if (h < 9'd20)      return 2'd0;
    else if (h < 9'd50) return 2'd1;
    else if (h < 9'd80) return 2'd2;
    else                return 2'd3;
  endfunction

  // Samples above 100 % are treated as garbage and ignored entirely,
  // including for the watchdog.
  assign accept = hum_valid && (hum_int <= 8'd100);
  assign expire = (tcnt == TO_LAST);

  // h+HYST in 9 bits so that 255+HYST cannot wrap; clamped to 100 %.
  assign h_ext     = {1'b0, hum_int};
  assign h_hyst    = ((h_ext + 9'(HYST)) > 9'd100) ? 9'd100 : (h_ext + 9'(HYST));
  assign band_h    = band(h_ext);
  assign band_hyst = band(h_hyst);

  // Rising humidity moves the band up immediately; falling humidity must
  // clear the lower band edge by HYST before the band drops.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so that
    // no path leaves it unassigned, which would infer a latch.
    run_level = level;
    if (band_h > level)         run_level = band_h;
    else if (band_hyst < level) run_level = band_hyst;
  end

  always_comb begin
    target = '0;
    case (state)
      S_RUN: begin
        case (level)
          2'd0:    target = TGT_L0;
          2'd1:    target = TGT_L1;
          2'd2:    target = TGT_L2;
          default: target = '0;
        endcase
      end
      S_FAULT: target = TGT_SAFE;
      default: target = '0;
    endcase
  end

  // One ramp step toward target, landing exactly on it rather than overshooting.
  always_comb begin
    duty_nxt = duty;
    if (duty < target) begin
      duty_nxt = ((target - duty) > STEP_W) ? (duty + STEP_W) : target;
    end else if (duty > target) begin
      duty_nxt = ((duty - target) > STEP_W) ? (duty - STEP_W) : target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      pcnt        <= '0;
      rcnt        <= '0;
      tcnt        <= '0;
      duty        <= '0;
      period_sync <= 1'b0;
      fan_en      <= 1'b0;
      level       <= 2'd0;
      fault       <= 1'b0;
    end else begin
      // NOTE: all state is assigned with <= so every register samples the
      // values from before this edge, independent of statement order.

      // Period counter and boundary strobe. duty/fan_en only move on the
      // same edge that raises period_sync, so the PWM never sees a mid-period
      // change.
      if (pcnt == P_LAST) begin
        pcnt        <= '0;
        period_sync <= 1'b1;
        if (rcnt == R_LAST) begin
          rcnt   <= '0;
          duty   <= duty_nxt;
          fan_en <= (duty_nxt != 10'd0);
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end else begin
        pcnt        <= pcnt + 1'b1;
        period_sync <= 1'b0;
      end

      // Watchdog: cleared by any accepted sample, otherwise saturating count.
      if (accept) begin
        tcnt <= '0;
      end else if (tcnt != '1) begin
        tcnt <= tcnt + 1'b1;
      end

      // An accepted sample always wins over a simultaneous expiry.
      case (state)
        S_IDLE: begin
          if (accept) begin
            level <= band_h;
            state <= S_RUN;
          end else if (expire) begin
            fault <= 1'b1;
            state <= S_FAULT;
          end
        end
        S_RUN: begin
          if (accept) begin
            level <= run_level;
          end else if (expire) begin
            fault <= 1'b1;
            state <= S_FAULT;
          end
        end
        S_FAULT: begin
          // Recovery takes the band directly: the held level is stale.
          if (accept) begin
            level <= band_h;
            fault <= 1'b0;
            state <= S_RUN;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hum_fan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hum_fan_ctrl
//
// Bench for hum_fan_ctrl. A behavioural model tracks, per clock edge, the
// number of edges since reset and the edge of the last accepted sample, and
// derives period boundaries, ramp steps and watchdog expiry from plain
// arithmetic on those. Every output is compared after every edge.
// -----------------------------------------------------------------------------
module tb_hum_fan_ctrl;

  localparam int PERIOD       = 100;
  localparam int RAMP_PERIODS = 1;
  localparam int STEP         = 10;
  localparam int HYST         = 5;
  localparam int TIMEOUT      = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hum_valid = 1'b0;
  logic [7:0] hum_int = 8'd0;
  logic [9:0] duty;
  logic       period_sync;
  logic       fan_en;
  logic [1:0] level;
  logic       fault;

  hum_fan_ctrl #(
    .PERIOD      (PERIOD),
    .RAMP_PERIODS(RAMP_PERIODS),
    .STEP        (STEP),
    .HYST        (HYST),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hum_valid  (hum_valid),
    .hum_int    (hum_int),
    .duty       (duty),
    .period_sync(period_sync),
    .fan_en     (fan_en),
    .level      (level),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_RUN, M_FAULT} mode_t;

  int    pct [4] = '{20, 50, 80, 0};
  mode_t m_mode;
  int    m_e;       // edges since reset release
  int    m_last;    // edge of last accepted sample (0 = reset)
  int    m_level;
  int    m_duty;
  bit    m_sync;
  bit    m_fault;

  function automatic int band_of(input int h);
    if (h < 20)      return 0;
    else if (h < 50) return 1;
    else if (h < 80) return 2;
    else             return 3;
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_e     = 0;
    m_last  = 0;
    m_level = 0;
    m_duty  = 0;
    m_sync  = 0;
    m_fault = 0;
  endtask

  task automatic model_edge(input bit v, input int h);
    bit acc;
    int tgt;
    int delta;
    int hh;
    acc = v && (h <= 100);
    m_e++;
    // Target seen at this edge is the one from before this edge's sample.
    if (m_mode == M_RUN)        tgt = (PERIOD - 1) * pct[m_level] / 100;
    else if (m_mode == M_FAULT) tgt = (PERIOD - 1) * 50 / 100;
    else                        tgt = 0;
    m_sync = (m_e % PERIOD == 0);
    if (m_sync && ((m_e / PERIOD) % RAMP_PERIODS == 0)) begin
      delta = tgt - m_duty;
      if (delta > STEP)  delta = STEP;
      if (delta < -STEP) delta = -STEP;
      m_duty = m_duty + delta;
    end
    if (acc) begin
      if (m_mode == M_RUN) begin
        hh = (h + HYST > 100) ? 100 : h + HYST;
        if (band_of(h) > m_level)       m_level = band_of(h);
        else if (band_of(hh) < m_level) m_level = band_of(hh);
      end else begin
        m_level = band_of(h);
      end
      m_mode  = M_RUN;
      m_fault = 0;
      m_last  = m_e;
    end else if ((m_e - m_last == TIMEOUT) && (m_mode != M_FAULT)) begin
      m_mode  = M_FAULT;
      m_fault = 1;
    end
  endtask

  task automatic check_all();
    check("duty",        32'(duty),        32'(m_duty));
    check("period_sync", 32'(period_sync), 32'(m_sync));
    check("fan_en",      32'(fan_en),      32'(m_duty != 0));
    check("level",       32'(level),       32'(m_level));
    check("fault",       32'(fault),       32'(m_fault));
  endtask

  // Drive one cycle of input, step the model with the DUT edge, compare.
  task automatic cycle(input bit v, input int h);
    hum_valid = v;
    hum_int   = 8'(h);
    @(posedge clk);
    model_edge(v, h);
    #1;
    check_all();
    hum_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int gap;
    int guard;

    model_reset();
    #2 rst = 1'b0;
    #15;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // Power-up ramp from IDLE into band 1.
    idle(9);
    cycle(1'b1, 35);
    check("level_after_35", 32'(level), 32'd1);
    idle(600);
    check("duty_settled_l1", 32'(duty), 32'd49);

    // Up into band 2, hold on 47 (hysteresis), drop on 44.
    cycle(1'b1, 50);
    idle(150);
    cycle(1'b1, 47);
    idle(150);
    cycle(1'b1, 44);
    idle(400);

    // Settle at band 2, then high humidity turns the fan off.
    cycle(1'b1, 60);
    idle(500);
    cycle(1'b1, 90);
    idle(1000);
    check("fan_off_at_l3", 32'(fan_en), 32'd0);

    // Band 0, then sensor goes silent.
    cycle(1'b1, 10);
    idle(2100);
    check("timeout_fault", 32'(fault), 32'd1);
    idle(500);
    cycle(1'b1, 10);
    check("fault_cleared", 32'(fault), 32'd0);
    idle(400);

    // Out-of-range sample must not feed the watchdog.
    cycle(1'b1, 120);
    idle(1700);
    check("bad_sample_no_clear", 32'(fault), 32'd1);

    // Accepted sample on the exact expiry cycle wins.
    cycle(1'b1, 30);
    guard = 0;
    while ((m_e - m_last < TIMEOUT - 1) && (guard < 5000)) begin
      cycle(1'b0, 0);
      guard++;
    end
    cycle(1'b1, 65);
    check("expiry_race_fault", 32'(fault), 32'd0);
    idle(5);
    check("expiry_race_hold", 32'(fault), 32'd0);

    // Randomized samples, with gaps sometimes straddling the timeout.
    for (int k = 0; k < 30; k++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1900, 2100))
                                        : int'($urandom_range(1, 300));
      idle(gap);
      cycle(1'b1, int'($urandom_range(0, 130)));
    end

    // Asynchronous reset in the middle of a ramp.
    cycle(1'b1, 70);
    idle(250);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
    idle(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hum_fan_ctrl.md
# hum_fan_ctrl

Closed-loop humidity fan controller that sits between the DHT11 readout path and the PWM generator. It turns sparse humidity samples into a glitch-free, slew-limited duty command with hysteresis, and it supplies the period-alignment strobe the PWM generator restarts on. A watchdog forces a safe duty when sensor samples stop arriving.

## Interface
Parameters
- `PERIOD`, 1000: PWM period in clk cycles; duty range 0..PERIOD-1.
- `RAMP_PERIODS`, 4: PWM periods between successive duty ramp steps.
- `STEP`, 25: maximum duty change per ramp step.
- `HYST`, 5: hysteresis in humidity percent, applied to downward band changes.
- `TIMEOUT`, 150_000_000: clk cycles without an accepted sample before fault.

Ports
- `clk`, in, 1: system clock. One clock domain.
- `rst`, in, 1: asynchronous, active-low reset.
- `hum_valid`, in, 1: one-cycle strobe; `hum_int` is valid in that cycle.
- `hum_int`, in, 8: integer relative humidity in percent.
- `duty`, out, 10: duty command (high cycles per period) to the PWM generator.
- `period_sync`, out, 1: one-cycle pulse marking the first cycle of each PWM period.
- `fan_en`, out, 1: high when `duty != 0`.
- `level`, out, 2: current humidity band 0..3.
- `fault`, out, 1: high while the sensor timeout is active.

## Operation
- Bands from humidity h: B0 h<20, B1 20..49, B2 50..79, B3 h>=80.
- Target duty per level uses (PERIOD-1)*pct/100 with integer truncation. L0=20%, L1=50%, L2=80%, L3=0 (fan off at high humidity). SAFE target is 50%.
- Accepted sample: `hum_valid`=1 and `hum_int`<=100. A sample above 100 is ignored completely: level does not change and the timeout counter is not cleared.
- States: IDLE (after reset, no sample yet), RUN, FAULT.
- IDLE:
  - Target = 0.
  - On an accepted sample, `level` = band(h) directly and the state moves to RUN.
  - Timeout expiry moves the state to FAULT.
- RUN, on an accepted sample:
  - If band(h) > level, `level` = band(h).
  - Else if band(min(h+HYST,100)) < level, `level` = band(h+HYST).
  - Otherwise `level` holds.
- FAULT:
  - `fault`=1, target = SAFE, `level` holds its last value.
  - On an accepted sample, `level` = band(h) directly (no hysteresis), `fault`=0, and the state moves to RUN.
- Timeout counter:
  - Cleared on every accepted sample.
  - Increments otherwise, saturating.
  - Expiry occurs when the count reaches TIMEOUT-1.
  - If an accepted sample and expiry occur in the same cycle, the sample wins: no fault, counter cleared.
- Ramp:
  - A ramp counter counts period boundaries.
  - Every RAMP_PERIODS-th boundary, `duty` moves toward target by STEP, clamped to land exactly on target (no overshoot).
  - Ramping applies in both directions.
  - `duty` never changes except at a period boundary.
- A target change mid-ramp takes effect at the next ramp step, starting from the current `duty`.

## Timing
- Reset (async assert, sync release): `duty`=0, `period_sync`=0, `fan_en`=0, `level`=0, `fault`=0. All counters are 0 and the state is IDLE.
- The period counter runs 0..PERIOD-1 and wraps.
- `period_sync` is registered. It is high in the cycle after the counter reads PERIOD-1. The first pulse comes PERIOD cycles after reset release.
- `duty` and `fan_en` update on the same edge that raises `period_sync`.
- `hum_valid` is sampled at edge N; `level`, `fault`, and target are updated at edge N+1. `duty` moves at the first qualifying ramp boundary after that.
- With RAMP_PERIODS=1, `duty` can change at every period boundary.
- `fault` rises one cycle after expiry and falls one cycle after an accepted sample.
- Reset asserted mid-ramp or mid-fault returns all outputs to their reset values immediately.
- Width rules:
  - `duty` is 10 bits; PERIOD must be <=1024.
  - The timeout counter is 32 bits, unsigned.
  - The h+HYST sum is computed in 9 bits.

## Test plan
Parameters for all scenarios: PERIOD=100, RAMP_PERIODS=1, STEP=10, HYST=5, TIMEOUT=2000. Targets: L0=19, L1=49, L2=79, SAFE=49.

- Reset, then `hum_valid`=35 at cycle 10 → `level`=1 at cycle 11. At successive `period_sync` pulses `duty` = 10, 20, 30, 40, 49, then holds. `fan_en`=1 from the first step.
- At level 1, samples 50, 47, 44 in sequence → `level` = 2, 2, 1. `duty` ramps toward 79, then back toward 49, changing only on `period_sync`.
- Sample 90 with `duty`=79 → `level`=3. `duty` steps 69, 59, … 9, 0. `fan_en` drops on the edge where `duty` reaches 0.
- No sample for 2000 cycles from RUN L0 → `fault`=1 and `duty` ramps to 49. Then sample 10 → `fault`=0 next cycle, `level`=0, `duty` ramps to 19.
- `hum_int`=120 with `hum_valid` → `level` unchanged and the timeout count is not cleared, so fault still occurs at the original time.
- Accepted sample in the exact cycle the counter hits 1999 → `fault` stays 0. Assert `rst` low mid-ramp → all outputs 0 asynchronously.
